// File: rtl/soc_system_sysid_checker.sv
// Reads the two sysid words over Avalon-MM and retries reads that time out.
// Reports whether both words match the expected build values.
module soc_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'd2899645186,
   parameter logic [31:0] EXPECTED_TS    = 32'd1493193839,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        err_timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   // The wait cycle holding this count is the last one allowed before a retry.
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  RetryMax    = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      StIdle,
      StReqId,
      StWaitId,
      StReqTs,
      StWaitTs,
      StCheck,
      StFinish
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic [3:0]  retry_q, retry_d;
   logic        pass_q, pass_d;
   logic        err_q, err_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;

   logic timeout_hit;
   logic retry_ok;

   assign timeout_hit = (tcnt_q == TimeoutLast);
   assign retry_ok    = (retry_q < RetryMax);

   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      retry_d     = retry_q;
      pass_d      = pass_q;
      err_d       = err_q;
      id_d        = id_q;
      ts_d        = ts_q;
      avm_read    = 1'b0;
      avm_address = 1'b0;
      done        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StReqId;
               pass_d  = 1'b0;
               err_d   = 1'b0;
               retry_d = '0;
               tcnt_d  = '0;
            end
         end

         StReqId, StReqTs: begin
            avm_read    = 1'b1;
            avm_address = (state_q == StReqTs);
            if (!avm_waitrequest) begin
               tcnt_d  = '0;
               state_d = (state_q == StReqId) ? StWaitId : StWaitTs;
            end
         end

         StWaitId, StWaitTs: begin
            // Data arriving on the terminal wait cycle takes priority over a retry.
            if (avm_readdatavalid) begin
               retry_d = '0;
               if (state_q == StWaitId) begin
                  id_d    = avm_readdata;
                  state_d = StReqTs;
               end else begin
                  ts_d    = avm_readdata;
                  state_d = StCheck;
               end
            end else if (timeout_hit) begin
               if (retry_ok) begin
                  retry_d = retry_q + 4'd1;
                  state_d = (state_q == StWaitId) ? StReqId : StReqTs;
               end else begin
                  err_d   = 1'b1;
                  pass_d  = 1'b0;
                  state_d = StFinish;
               end
            end else if (tcnt_q != '1) begin
               tcnt_d = tcnt_q + 16'd1;
            end
         end

         StCheck: begin
            pass_d  = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
            state_d = StFinish;
         end

         StFinish: begin
            done    = 1'b1;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= StIdle;
         tcnt_q  <= '0;
         retry_q <= '0;
         pass_q  <= 1'b0;
         err_q   <= 1'b0;
         id_q    <= '0;
         ts_q    <= '0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         retry_q <= retry_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         id_q    <= id_d;
         ts_q    <= ts_d;
      end
   end

   assign busy        = (state_q != StIdle);
   assign pass        = pass_q;
   assign err_timeout = err_q;
   assign id_value    = id_q;
   assign ts_value    = ts_q;

endmodule

// File: doc/soc_system_sysid_checker.md
SOC_SYSTEM_SYSID_CHECKER -- requirements
Module: soc_system_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 2899645186, meaning the 32-bit system ID expected at slave word 0.
REQ-002 Parameter EXPECTED_TS, default 1493193839, meaning the 32-bit build timestamp expected at slave word 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles to wait for readdatavalid per read, range 1..65535.
REQ-004 Parameter MAX_RETRIES, default 3, meaning the number of re-issues of a timed-out read before error, range 0..15.
REQ-005 The block SHALL have one clock, with reset synchronous and active-low, on ports named clock and reset_n.
REQ-006 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port reset_n, input, 1 bit: synchronous active-low reset.
REQ-008 Port start, input, 1 bit: one-cycle pulse that begins a check sequence.
REQ-009 Port avm_address, output, 1 bit: sysid word select (0 = ID, 1 = timestamp).
REQ-010 Port avm_read, output, 1 bit: Avalon-MM read request.
REQ-011 Port avm_waitrequest, input, 1 bit: slave stall.
REQ-012 Port avm_readdata, input, 32 bits: read data.
REQ-013 Port avm_readdatavalid, input, 1 bit: readdata qualifier.
REQ-014 Port busy, output, 1 bit: sequence in progress.
REQ-015 Port done, output, 1 bit: one-cycle pulse when a sequence ends.
REQ-016 Port pass, output, 1 bit: sticky result, both words matched.
REQ-017 Port err_timeout, output, 1 bit: sticky result, retries exhausted.
REQ-018 Port id_value and ts_value, output, 32 bits each: last captured words.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, CHECK and FINISH.
REQ-020 IDLE: start=1 -> REQ_ID; clear pass, err_timeout, retry counter and timeout counter.
REQ-021 REQ_xx: avm_read=1 with the matching avm_address; hold both while avm_waitrequest=1; in the cycle where waitrequest=0, go to WAIT_xx and load the timeout counter with 0.
REQ-022 WAIT_xx: avm_read=0; on avm_readdatavalid=1, capture avm_readdata into id_value/ts_value; next state REQ_TS after WAIT_ID, CHECK after WAIT_TS.
REQ-023 WAIT_xx: the timeout counter SHALL increment each cycle without valid; on reaching TIMEOUT_CYCLES with retries < MAX_RETRIES, increment the retry count and re-enter the same REQ_xx.
REQ-024 On timeout with retries = MAX_RETRIES: set err_timeout=1, pass=0, go to FINISH.
REQ-025 The retry counter SHALL reset to 0 on each successful capture, so the budget applies per word.
REQ-026 CHECK, 1 cycle: pass = (id_value==EXPECTED_ID) and (ts_value==EXPECTED_TS); -> FINISH.
REQ-027 FINISH: done=1 for exactly one cycle; -> IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 readdatavalid in IDLE/REQ_xx/CHECK/FINISH SHALL be ignored, with no capture.
REQ-031 readdatavalid coinciding with the timeout-terminal cycle SHALL win: capture, no retry.
REQ-032 Zero-latency slave: readdatavalid may assert the cycle after the accepted read; minimum sequence length is 6 cycles from start to done.
REQ-033 Comparisons SHALL be full 32-bit unsigned equality; counters SHALL saturate, not wrap.

Reset
REQ-034 reset_n=0 at a clock edge SHALL force IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, err_timeout=0, id_value=0, ts_value=0, and counters to 0, including mid-sequence.
REQ-035 A readdatavalid arriving after reset from a pre-reset read SHALL be ignored (per REQ-030).

Verification
REQ-036 Slave returns 2899645186 and 1493193839 with 1-cycle latency, start pulse -> done on cycle 6, pass=1, err_timeout=0.
REQ-037 Timestamp word returns 1493193840 -> done, pass=0, err_timeout=0, ts_value=1493193840.
REQ-038 waitrequest held for 5 cycles on each read -> avm_read/avm_address stable throughout, then pass=1.
REQ-039 readdatavalid never asserted for word 0, with TIMEOUT_CYCLES=4 and MAX_RETRIES=2 -> 3 read issues to address 0, then err_timeout=1, pass=0, done pulse, no address-1 read.
REQ-040 reset_n=0 during WAIT_TS, followed by a stale valid -> all outputs 0, stays IDLE, no capture.
REQ-041 start pulsed again mid-sequence -> ignored; exactly one done pulse.
